dmem_access_ctrl: RTL and testbench

Sequences data-memory accesses for the MEM stage of the 5-stage pipeline against a variable-latency data memory with a req/ack handshake. It freezes the upstream pipeline while an access is outstanding and forces bubbles into MEM_WB. It delivers the load data to the MEM_WB read-data input on the cycle the pipeline is released.

---
 rtl/dmem_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack handshake, pipeline stall and MEM_WB bubble control.
// Optional build macro DMEM_TIMEOUT_EN adds an abort when the memory does not answer within TIMEOUT_CYC cycles.
module dmem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_valid,
    input  logic              ex_mem_mem_read,
    input  logic              ex_mem_mem_write,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              mem_wb_bubble,
    output logic [DATA_W-1:0] rdata_out,
    output logic              misalign_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                timeout_q, timeout_d;
    logic                access_s, aligned_s;
    logic                stall_s, bubble_s, req_s, misalign_s;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign access_s  = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign aligned_s = (ex_mem_addr[1:0] == 2'b00);

    // Next-state, request capture and combinational handshake/stall decode
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        timeout_d  = 1'b0;
        stall_s    = 1'b0;
        bubble_s   = 1'b0;
        req_s      = 1'b0;
        misalign_s = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    bubble_s = 1'b1;
                    if (aligned_s) begin
                        stall_s = 1'b1;
                        we_d    = ex_mem_mem_write;  // read+write resolves to a write
                        addr_d  = ex_mem_addr;
                        wdata_d = ex_mem_wdata;
                        state_d = S_REQ;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d   = {CNT_W{1'b0}};
`endif
                    end else begin
                        misalign_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ, S_WAIT: begin
                req_s    = 1'b1;
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = S_DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rdata_d   = DATA_W'(32'hDEADBEEF);
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Cycles spent in REQ/WAIT without an acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Combinational controls are masked during reset so a dropped request never leaks out
    assign mem_req       = req_s & ~rst;
    assign stall         = stall_s & ~rst;
    assign mem_wb_bubble = bubble_s & ~rst;
    assign misalign_err  = misalign_s & ~rst;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign rdata_out     = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl; one task per scenario.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_valid = 1'b0;
    logic        ex_mem_mem_read = 1'b0;
    logic        ex_mem_mem_write = 1'b0;
    logic [31:0] ex_mem_addr = 32'h0;
    logic [31:0] ex_mem_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        stall;
    logic        mem_wb_bubble;
    logic [31:0] rdata_out;
    logic        misalign_err;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid(ex_mem_valid), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_mem_wdata(ex_mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .mem_wb_bubble(mem_wb_bubble), .rdata_out(rdata_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        ex_mem_valid = v; ex_mem_mem_read = rd; ex_mem_mem_write = wr;
        ex_mem_addr = a; ex_mem_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(1'b1, 1'b1, $urandom_range(1, 0) == 1, $urandom, $urandom);
            mem_ack = 1'b1; mem_rdata = $urandom;
            #1;
            checks++;
            if ({stall, mem_wb_bubble, mem_req, mem_we, misalign_err, timeout_err} !== 6'b0) begin
                failures++;
                $display("FAIL reset_ctrl cyc%0d got=%b want=000000", i,
                         {stall, mem_wb_bubble, mem_req, mem_we, misalign_err, timeout_err});
            end
            checks++;
            if ({mem_addr, mem_wdata, rdata_out} !== 96'h0) begin
                failures++;
                $display("FAIL reset_data cyc%0d addr=%h wdata=%h rdata=%h want=0", i,
                         mem_addr, mem_wdata, rdata_out);
            end
        end
        tick();
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_load();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        checks++;
        if ({stall, mem_wb_bubble, mem_req} !== 3'b110) begin
            failures++; $display("FAIL load_t0 got=%b want=110", {stall, mem_wb_bubble, mem_req});
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({mem_req, mem_we, stall} !== 3'b101 || mem_addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL load_t1 req/we/stall=%b addr=%h want=101 addr=00000100",
                     {mem_req, mem_we, stall}, mem_addr);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if ({stall, mem_wb_bubble, mem_req} !== 3'b000 || rdata_out !== 32'h1234_5678) begin
            failures++;
            $display("FAIL load_t2 ctrl=%b rdata=%h want=000 12345678",
                     {stall, mem_wb_bubble, mem_req}, rdata_out);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_store();
        int req_cnt = 0;
        int stall_cnt = 0;
        logic held_ok = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D);
        #1;
        if (stall) stall_cnt++;
        for (int i = 1; i < 20; i++) begin
            tick();
            mem_ack = (i == 6);
            mem_rdata = 32'h0BAD_0BAD;
            ex_mem_wdata = 32'h1111_1111;
            #1;
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== 32'h0000_0204 || mem_wdata !== 32'hCAFE_F00D || mem_we !== 1'b1)
                    held_ok = 1'b0;
            end
            if (stall) stall_cnt++;
            else break;
        end
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (req_cnt != 6) begin
            failures++; $display("FAIL store_req_cycles got=%0d want=6", req_cnt);
        end
        checks++;
        if (stall_cnt != 7) begin
            failures++; $display("FAIL store_stall_cycles got=%0d want=7", stall_cnt);
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++; $display("FAIL store_hold got=%b want=1", held_ok);
        end
        checks++;
        if (rdata_out !== 32'h1234_5678) begin
            failures++; $display("FAIL store_rdata got=%h want=12345678", rdata_out);
        end
    endtask

    task automatic test_misalign();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0);
        #1;
        checks++;
        if ({misalign_err, stall, mem_wb_bubble, mem_req} !== 4'b1010) begin
            failures++;
            $display("FAIL misalign_t0 got=%b want=1010",
                     {misalign_err, stall, mem_wb_bubble, mem_req});
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        #1;
        checks++;
        if ({misalign_err, stall, mem_req} !== 3'b000) begin
            failures++;
            $display("FAIL misalign_t1 got=%b want=000", {misalign_err, stall, mem_req});
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (rdata_out !== 32'h1234_5678 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_ignored rdata=%h req=%b want=12345678 0", rdata_out, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL b2b_done stall=%b req=%b want=0 0", stall, mem_req);
        end
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA);
        #1;
        checks++;
        if (stall !== 1'b1 || rdata_out !== 32'h0000_BEEF) begin
            failures++; $display("FAIL b2b_t3 stall=%b rdata=%h want=1 0000beef", stall, rdata_out);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        #1;
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h0000_0020 || mem_wdata !== 32'h55AA_55AA) begin
            failures++;
            $display("FAIL rw_as_write req/we=%b addr=%h wdata=%h want=11 00000020 55aa55aa",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rdata_out !== 32'h0000_BEEF || misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_store_done stall=%b rdata=%h err=%b want=0 0000beef 0",
                     stall, rdata_out, misalign_err);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_rst_wait();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0280, 32'h0);
        tick();
        tick();
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b11) begin
            failures++; $display("FAIL rst_wait_pre got=%b want=11", {mem_req, stall});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            failures++; $display("FAIL rst_wait_after got=%b want=00", {mem_req, stall});
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (rdata_out !== 32'h0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL late_ack rdata=%h req=%b want=0 0", rdata_out, mem_req);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300) begin
            failures++; $display("FAIL post_rst_req req=%b addr=%h want=1 00000300", mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b0 || rdata_out !== 32'hA5A5_5A5A) begin
            failures++; $display("FAIL post_rst_done stall=%b rdata=%h want=0 a5a55a5a", stall, rdata_out);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic seen_to = 1'b0;
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (timeout_err) begin
                seen_to = 1'b1;
                break;
            end
            if (mem_req) n++;
        end
        checks++;
        if (seen_to !== 1'b1 || n != 8) begin
            failures++; $display("FAIL timeout_cycles seen=%b req_cycles=%0d want=1 8", seen_to, n);
        end
        checks++;
        if (rdata_out !== 32'hDEAD_BEEF || stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_state rdata=%h stall=%b req=%b want=deadbeef 0 0",
                     rdata_out, stall, mem_req);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++; $display("FAIL timeout_pulse got=%b want=0", timeout_err);
        end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            #1;
            if (timeout_err) seen_to = 1'b1;
            if (mem_req) n++;
        end
        checks++;
        if (stall !== 1'b1 || seen_to !== 1'b0 || n != 100) begin
            failures++;
            $display("FAIL no_timeout stall=%b timeout_seen=%b req_cycles=%0d want=1 0 100",
                     stall, seen_to, n);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL no_timeout_recover stall=%b req=%b want=0 0", stall, mem_req);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_rst_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
